// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite slave register file with NUM_REGS 32-bit registers.
// Supports byte-strobe writes and accepts AW and W independently.
// Exports the register contents and a one-cycle write pulse for each register.
// Optional feature: define AXIL_REGFILE_SLVERR_EN so that out-of-range accesses return SLVERR.
// Without it, out-of-range accesses return OKAY.
module axil_regfile_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_MISS = 2'b10;
`else
  localparam logic [1:0] RESP_MISS = 2'b00;
`endif

  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic                  aw_hs, w_hs, ar_hs, wr_commit, wr_hit, rd_hit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data, rd_val;
  logic [STRB_W-1:0]     wr_strb;
  logic                  unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ARESETN & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = ARESETN & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = ARESETN & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

  assign aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_idx    = aw_held_q ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data   = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb   = w_held_q ? w_strb_q : S_AXI_WSTRB;
  assign rd_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  // Write path: latch AW/W, commit once both are present, then hold B until it is accepted
  always_comb begin
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    wr_hit     = 1'b0;
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (wr_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          wr_hit        = 1'b1;
          wr_pulse_d[k] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
      bresp_d = wr_hit ? RESP_OKAY : RESP_MISS;
    end
  end

  // Read path: capture the pre-write register value on AR handshake and hold it until R is accepted
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rd_hit   = 1'b0;
    rd_val   = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        rd_hit = 1'b1;
        rd_val = regs_q[k];
      end
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_MISS;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; the asynchronous reset discards any in-flight transaction
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

endmodule

// File: doc/axil_regfile_slave.md
# axil_regfile_slave

AXI4-Lite slave register file that terminates the S00_AXI port of the custom IP. It is the block directly downstream of the AXI4-Lite master VIP in the example design. It holds NUM_REGS software-visible 32-bit registers with byte-strobe writes and decoupled AW/W acceptance. It exports register contents and per-register write pulses to the IP core.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI address width; word index = ADDR[ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of implemented registers; must be ≤ 2^(ADDR_WIDTH-2).
- ACLK  in  1  single clock; all logic rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR / AWPROT / AWVALID  in  ADDR_WIDTH / 3 / 1  write address channel; AWPROT ignored.
- S_AXI_AWREADY  out  1  write address accept.
- S_AXI_WDATA / WSTRB / WVALID  in  32 / 4 / 1  write data channel.
- S_AXI_WREADY  out  1  write data accept.
- S_AXI_BRESP / BVALID  out  2 / 1  write response; S_AXI_BREADY  in  1.
- S_AXI_ARADDR / ARPROT / ARVALID  in  ADDR_WIDTH / 3 / 1  read address; ARPROT ignored.
- S_AXI_ARREADY  out  1  read address accept.
- S_AXI_RDATA / RRESP / RVALID  out  32 / 2 / 1  read data; S_AXI_RREADY  in  1.
- regs_o  out  NUM_REGS*32  register contents; register k at bits [32k+31:32k].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse when register k is written (any strobe).

## Operation
- Write side state: aw_held (latched address), w_held (latched data+strobe), BVALID.
- AWREADY = ARESETN & !aw_held & !BVALID; WREADY = ARESETN & !w_held & !BVALID.
- AW and W may arrive in either order, any gap, or together; each is latched on its handshake.
- Commit: on the edge where the address and the data are each either held or handshaking, the register is updated byte-wise (byte b written iff WSTRB[b]). BVALID is set, aw_held/w_held are cleared, and wr_pulse_o[k] is set for one cycle.
- WSTRB = 0: no bytes change, wr_pulse_o still fires, BRESP=OKAY.
- BVALID held with BRESP stable until BREADY; cleared on the BVALID&BREADY edge. Only one write is outstanding.
- Read: ARREADY = ARESETN & !RVALID. On an AR handshake, RDATA/RRESP are registered and RVALID is set. All are held stable until RREADY.
- Same-edge read and write commit to the same register: the read returns the pre-write value.
- Address low bits [1:0] are ignored (unaligned address maps to the containing word).

## Timing
- Reset (asynchronous assert): regs_o=0, wr_pulse_o=0, BVALID=0, BRESP=00, RVALID=0, RRESP=00, RDATA=0, aw_held=w_held=0. All READYs are 0 while ARESETN=0.
- First cycle after deassertion: AWREADY=WREADY=ARREADY=1.
- AW+W handshake in cycle N: regs_o updated, wr_pulse_o=1 and BVALID=1 in N+1. With BREADY=1 in N+1, AWREADY/WREADY return to 1 in N+2. Peak throughput is 1 write per 2 cycles.
- AR handshake in cycle N: RVALID and RDATA valid in N+1. With RREADY=1, ARREADY=1 in N+2.
- Reset mid-transaction: latched AW/W and pending B/R are discarded; no response is issued afterwards.
- Read and write paths are independent; simultaneous activity does not stall either.

## Configuration
- AXIL_REGFILE_SLVERR_EN defined: out-of-range index (≥ NUM_REGS) gives BRESP/RRESP = 2'b10 (SLVERR). The write is dropped, there is no wr_pulse_o, and RDATA=0.
- Not defined: out-of-range accesses respond OKAY. Writes are silently dropped (no pulse) and reads return 0.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB=0xF -> all BRESP=OKAY; readback returns 0x1..0x4 and regs_o matches.
- reg0=0x00000001, then write 0xAABBCCDD with WSTRB=0b0101 -> reg0 reads 0x00BB00DD; wr_pulse_o[0] high exactly one cycle.
- W presented 3 cycles before AW; BREADY held low 5 cycles -> data latched, BVALID stays high with BRESP stable, AWREADY/WREADY low until the B handshake.
- Same cycle: AR to 0x4 and commit of 0xDEADBEEF to 0x4 (old value 0x2) -> RDATA=0x2; following read returns 0xDEADBEEF.
- ADDR_WIDTH=5: access to 0x10 -> SLVERR, RDATA=0, regs unchanged with macro; OKAY, RDATA=0, regs unchanged without.
- ARESETN low for 1 cycle while BVALID=1 and RVALID=1 -> all outputs return to reset values and no stale response appears after release.
